// File: rtl/alu_flag_cond_unit.sv
// ALU result/flag consumer: condition check against PSR, flag commit, one-stage valid/ready result register.
// Optional build macro PSR_WRITE_EN adds a direct PSR write port (psr_wr/psr_wdata) that overrides flag commits.
module alu_flag_cond_unit #(
  parameter int unsigned DATA_W    = 32,
  parameter logic [3:0]  PSR_RESET = 4'b0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] Out,
  input  logic              Z,
  input  logic              N,
  input  logic              C,
  input  logic              V,
  input  logic [3:0]        cond,
  input  logic              s_bit,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_exec,
  output logic [3:0]        psr,
  output logic [15:0]       squash_cnt
`ifdef PSR_WRITE_EN
  ,
  input  logic              psr_wr,
  input  logic [3:0]        psr_wdata
`endif
);

  localparam int unsigned CNT_W   = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  logic              res_valid_q, res_valid_d;
  logic [DATA_W-1:0] res_data_q,  res_data_d;
  logic              res_exec_q,  res_exec_d;
  logic [3:0]        psr_q,       psr_d;
  logic [CNT_W-1:0]  squash_q,    squash_d;

  logic psr_n, psr_z, psr_c, psr_v;
  logic pass_c;
  logic accept_c;

  assign psr_n = psr_q[3];
  assign psr_z = psr_q[2];
  assign psr_c = psr_q[1];
  assign psr_v = psr_q[0];

  // Condition sees only the architectural PSR, never the beat's own flags.
  always_comb begin
    pass_c = 1'b0;
    unique case (cond)
      COND_EQ: pass_c = psr_z;
      COND_NE: pass_c = !psr_z;
      COND_CS: pass_c = psr_c;
      COND_CC: pass_c = !psr_c;
      COND_MI: pass_c = psr_n;
      COND_PL: pass_c = !psr_n;
      COND_VS: pass_c = psr_v;
      COND_VC: pass_c = !psr_v;
      COND_HI: pass_c = psr_c & !psr_z;
      COND_LS: pass_c = !psr_c | psr_z;
      COND_GE: pass_c = (psr_n == psr_v);
      COND_LT: pass_c = (psr_n != psr_v);
      COND_GT: pass_c = !psr_z & (psr_n == psr_v);
      COND_LE: pass_c = psr_z | (psr_n != psr_v);
      COND_AL: pass_c = 1'b1;
      default: pass_c = 1'b0;
    endcase
  end

  assign in_ready = !res_valid_q | res_ready;
  assign accept_c = in_valid & in_ready;

  // Next-state for the result register, PSR and squash counter.
  always_comb begin
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_exec_d  = res_exec_q;
    psr_d       = psr_q;
    squash_d    = squash_q;

    if (accept_c) begin
      res_valid_d = 1'b1;
      res_data_d  = Out;
      res_exec_d  = pass_c;
      if (pass_c && s_bit) begin
        psr_d = {N, Z, C, V};
      end
      if (!pass_c && (squash_q != CNT_MAX)) begin
        squash_d = squash_q + CNT_W'(1);
      end
    end else if (res_ready) begin
      res_valid_d = 1'b0;
    end

`ifdef PSR_WRITE_EN
    if (psr_wr) begin
      psr_d = psr_wdata;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_exec_q  <= 1'b0;
      psr_q       <= PSR_RESET;
      squash_q    <= '0;
    end else begin
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_exec_q  <= res_exec_d;
      psr_q       <= psr_d;
      squash_q    <= squash_d;
    end
  end

  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_exec   = res_exec_q;
  assign psr        = psr_q;
  assign squash_cnt = squash_q;

endmodule

// File: doc/alu_flag_cond_unit.md
Name: alu_flag_cond_unit

Overview:
- Consumer end of the ALU result/flag interface: accepts one ALU result beat (Out plus Z/N/C/V) with the instruction's condition field and S bit.
- Evaluates the condition against the architectural status register (PSR) and commits flags to the PSR when the instruction executes with S set.
- Forwards a registered, condition-qualified result to writeback through a single-stage valid/ready pipeline register.
- Sits between the ALU and the register-file writeback / branch logic.

Parameters:
- DATA_W, 32, width of ALU result path
- PSR_RESET, 4'b0000, reset value of {N,Z,C,V}

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  ALU beat present
- in_ready  out  1  unit can accept beat
- Out  in  DATA_W  ALU result
- Z  in  1  ALU zero flag
- N  in  1  ALU negative flag
- C  in  1  ALU carry flag
- V  in  1  ALU overflow flag
- cond  in  4  condition field
- s_bit  in  1  update flags if executed
- res_valid  out  1  output beat valid
- res_ready  in  1  downstream accepts beat
- res_data  out  DATA_W  registered Out
- res_exec  out  1  condition passed (writeback enable)
- psr  out  4  current {N,Z,C,V}
- squash_cnt  out  16  count of failed-condition beats

Behaviour:
- Reset (async, active-high; takes effect immediately, independent of clk):
  - psr=PSR_RESET
  - res_valid=0, res_data=0, res_exec=0, squash_cnt=0
  - in_ready=1 while reset is low after release
  - An in-flight output beat is dropped; no PSR update occurs for a beat presented during reset.
- Handshake:
  - Define in_ready = !res_valid | res_ready (combinational).
  - A beat is accepted on a rising edge where in_valid & in_ready.
  - Output beat completes on a rising edge where res_valid & res_ready.
  - Accept and complete in the same cycle is allowed; this gives full throughput.
- Latency: 1 cycle. A beat accepted at edge k is visible at res_* after edge k.
- Hold rule: while res_valid & !res_ready, res_data and res_exec are held stable. Upstream must hold its inputs while in_ready=0.
- Condition evaluation is combinational against the psr register value (the pre-update value). The beat's own Z/N/C/V are never used for its own condition.
  - 0000 EQ: Z
  - 0001 NE: !Z
  - 0010 CS: C
  - 0011 CC: !C
  - 0100 MI: N
  - 0101 PL: !N
  - 0110 VS: V
  - 0111 VC: !V
  - 1000 HI: C&!Z
  - 1001 LS: !C|Z
  - 1010 GE: N==V
  - 1011 LT: N!=V
  - 1100 GT: !Z&(N==V)
  - 1101 LE: Z|(N!=V)
  - 1110 AL: 1
  - 1111 NV: 0
- On accept:
  - res_data <= Out, registered regardless of pass.
  - res_exec <= pass; res_valid <= 1.
  - If pass & s_bit: psr <= {N,Z,C,V} at that edge.
  - If !pass: squash_cnt increments, saturating at 16'hFFFF.
- Back-to-back beats: the second beat sees the psr written by the first, because the update occurs at the first beat's accept edge.
- Without an accept, a completing output clears res_valid; res_data and res_exec retain their last values.
- Flags never update on a rejected (in_ready=0) beat or a failed-condition beat.

Optional Feature:
- Macro: PSR_WRITE_EN
- When defined, adds ports psr_wr (in, 1) and psr_wdata (in, 4), a direct status-register write.
  - psr_wr loads psr <= psr_wdata at the edge, independent of the handshake.
  - If psr_wr coincides with an accepted s_bit beat that passes, psr_wr wins.
  - Condition evaluation in that cycle still uses the old psr.
- When undefined, the ports are absent and psr changes only via executed s_bit beats.

Test Plan:
- Reset mid-stream: assert reset with res_valid=1 and res_ready=0 -> res_valid=0, psr=0000 and squash_cnt=0 immediately, without waiting for a clock edge.
- Add with flag update: Out=32'h0C00003B, C=1, N=Z=V=0, cond=1110, s_bit=1 -> next cycle res_data=32'h0C00003B, res_exec=1, psr=0010.
- Conditional pass/fail:
  - With psr=0010, cond=0010 (CS) -> res_exec=1.
  - cond=0011 (CC) -> res_exec=0, squash_cnt=1, psr unchanged although s_bit=1.
- Back-to-back dependency:
  - Beat 1: AL, s_bit=1, Z=1.
  - Beat 2 accepted the next cycle: cond=0000 (EQ) -> beat 2 res_exec=1.
  - Beat 2 with cond=0001 instead -> res_exec=0.
- Backpressure:
  - Hold res_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, res_data stable, psr unchanged.
  - Release res_ready -> one accept per cycle thereafter, no beat lost or duplicated.
- With PSR_WRITE_EN: psr_wr=1, psr_wdata=1000, in the same cycle as a passing s_bit beat carrying Z=1 -> psr=1000. A following cond=0100 (MI) -> res_exec=1.
